cmd_start_pulser: RTL and testbench
===================================

// Module: cmd_start_pulser
// PURPOSE
//  Programmable trigger-pulse generator feeding the EXT_START input of the command sequencer.
//  On a bus start or a qualified external edge it waits DELAY cycles, drives PULSE_OUT for WIDTH cycles,
//  and repeats REPEAT times. It times FE command bursts against external events without software latency.
//  Bus-mapped on the same 8-bit BUS_* interface as the other MultiIO peripherals.
// PARAMETERS
//  BASEADDR_BITS  4  decoded low address bits; registers occupy 0..15, upper BUS_ADD bits must be 0
// PORTS
//  BUS_CLK       in   1   single clock for bus and pulse logic
//  BUS_RST_N     in   1   reset, asynchronous, active-low
//  BUS_ADD       in   16  register address
//  BUS_DATA_IN   in   8   write data
//  BUS_RD        in   1   read strobe
//  BUS_WR        in   1   write strobe
//  BUS_DATA_OUT  out  8   read data, registered, valid 1 cycle after address
//  EXT_START     in   1   asynchronous external trigger
//  PULSE_OUT     out  1   generated pulse, registered; goes to sequencer EXT_START
//  BUSY          out  1   high while state != IDLE
// BEHAVIOUR
//  Register map:
//   0 W: soft reset (clears config to defaults, FSM to IDLE); R: 0
//   1 W: START (data ignored); R: {7'b0, READY}. READY = (state==IDLE)
//   2 RW: bit0 EN_EXT_START, bit1 EXT_NEGEDGE, bit2 INVERT_OUT, bits7:3 stored, no effect
//   3/4 RW: DELAY[7:0]/[15:8]   5/6 RW: WIDTH lo/hi   7/8 RW: REPEAT lo/hi
//   9/10 R: PULSE_CNT lo/hi (see CONFIGURATION); 11..15 R: 0
//  Defaults after either reset: reg2=0, DELAY=0, WIDTH=1, REPEAT=1.
//  BUS_RST_N low: all flops to defaults asynchronously. PULSE_OUT=0, BUSY=0, BUS_DATA_OUT=0.
//  Soft reset is synchronous and acts at the edge where the write is sampled.
//  EXT_START: 2-flop synchronizer, then edge detect on the synchronized pair (rising, or falling if EXT_NEGEDGE).
//   The resulting trigger is valid 3 BUS_CLK edges after the input changes. It is gated by EN_EXT_START.
//  FSM: IDLE -> DLY on trigger (bus START or ext edge). DLY -> HIGH when dly_cnt==DELAY.
//   HIGH -> DLY when wid_cnt==WIDTH-1 and more repeats remain.
//   HIGH -> IDLE when wid_cnt==WIDTH-1 and rep_cnt==REPEAT.
//  Timing: if a trigger is sampled at edge N, PULSE_OUT (non-inverted) is 1 from edge N+1+DELAY
//   for exactly WIDTH cycles. Each later repetition uses the same DELAY low time before its high time.
//  WIDTH=0 is treated as 1. DELAY=0 gives the first high at edge N+1.
//  REPEAT=0 runs forever until soft reset. rep_cnt is 16-bit and never wraps in infinite mode (it saturates).
//  INVERT_OUT: PULSE_OUT = active ^ INVERT_OUT; the idle level follows INVERT_OUT immediately.
//  Triggers arriving while state != IDLE are dropped, not queued.
//  A bus START and an ext edge in the same cycle count as a single trigger.
//  Config writes while busy take effect at the next compare; software must not change WIDTH/DELAY mid-run.
//  Soft reset mid-pulse: PULSE_OUT returns to the idle level on the next edge, BUSY=0, READY=1.
//  Bus read latency: 1 cycle, reads are side-effect free. Reads are allowed while busy.
// CONFIGURATION
//  CMD_PULSER_PULSE_CNT_EN defined: 16-bit PULSE_CNT counts PULSE_OUT active-level entries.
//   It saturates at 16'hFFFF, is cleared by trigger acceptance and by both resets, and reads at 9/10.
//  Not defined: no counter logic; addresses 9/10 read 0.
// TESTING
//  T1 reset: BUS_RST_N=0 mid-run -> PULSE_OUT=0, BUSY=0 immediately; reg3..8 read 00,00,01,00,01,00.
//  T2 DELAY=5, WIDTH=3, REPEAT=1, START at edge 100 -> PULSE_OUT high edges 106..108; READY=1 from 109.
//  T3 DELAY=0, WIDTH=2, REPEAT=4 -> 4 pulses, high 2 low 0 (contiguous high 8 cycles); PULSE_CNT=4 (if _EN).
//  T4 EN_EXT_START=1, EXT_NEGEDGE=1, DELAY=2, WIDTH=1: EXT_START 1->0 -> PULSE_OUT high 6 edges later.
//   A second edge while busy is ignored; with EN_EXT_START=0 there is no response.
//  T5 REPEAT=0, DELAY=1, WIDTH=1 -> continuous 50% toggle for 1000 cycles; soft reset write stops it next edge.
//  T6 INVERT_OUT=1 -> idle 1, pulse low WIDTH cycles; START and EXT edge in same cycle -> exactly one sequence.

Source files
------------

// File: rtl/cmd_start_pulser_if.sv
// ---------------------------------------------------------------------------
// cmd_start_pulser_if : 8-bit MultiIO register bus shared with the pulser.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cmd_start_pulser_if;
  logic [15:0] BUS_ADD;
  logic [7:0]  BUS_DATA_IN;
  logic        BUS_RD;
  logic        BUS_WR;
  logic [7:0]  BUS_DATA_OUT;

  modport master (
    output BUS_ADD,
    output BUS_DATA_IN,
    output BUS_RD,
    output BUS_WR,
    input  BUS_DATA_OUT
  );

  modport slave (
    input  BUS_ADD,
    input  BUS_DATA_IN,
    input  BUS_RD,
    input  BUS_WR,
    output BUS_DATA_OUT
  );
endinterface

`default_nettype wire

// File: rtl/cmd_start_pulser.sv
// ---------------------------------------------------------------------------
// cmd_start_pulser : programmable delay/width/repeat trigger pulse generator.
// Optional PULSE_CNT counter enabled by defining CMD_PULSER_PULSE_CNT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cmd_start_pulser #(
  parameter int BASEADDR_BITS = 4
) (
  input  wire logic         BUS_CLK,
  input  wire logic         BUS_RST_N,
  cmd_start_pulser_if.slave bus,
  input  wire logic         EXT_START,
  output logic              PULSE_OUT,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DLY  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_active;
  logic [15:0] r_dly_cnt;
  logic [15:0] r_wid_cnt;
  logic [15:0] r_rep_cnt;

  logic [7:0]  r_ctrl;
  logic [15:0] r_delay;
  logic [15:0] r_width;
  logic [15:0] r_repeat;
  logic [2:0]  r_sync;
  logic [7:0]  r_data_out;

  logic        w_addr_ok;
  logic [3:0]  w_idx;
  logic        w_wr;
  logic        w_soft_rst;
  logic        w_bus_start;
  logic        w_ext_edge;
  logic        w_trigger;
  logic        w_accept;
  logic [15:0] w_width_eff;
  logic        w_wid_done;
  logic        w_last;
  logic        w_enter_high;
  logic [15:0] w_pulse_cnt;
  logic [7:0]  w_rd_data;

  assign w_addr_ok   = ((bus.BUS_ADD >> BASEADDR_BITS) == 16'h0000);
  assign w_idx       = bus.BUS_ADD[3:0];
  assign w_wr        = bus.BUS_WR && w_addr_ok;
  assign w_soft_rst  = w_wr && (w_idx == 4'd0);
  assign w_bus_start = w_wr && (w_idx == 4'd1);

  // Edge detect on the 2nd/3rd flops so the trigger is sampled 3 edges after the pin moves
  assign w_ext_edge = r_ctrl[1] ? (!r_sync[1] && r_sync[2]) : (r_sync[1] && !r_sync[2]);
  assign w_trigger  = w_bus_start || (r_ctrl[0] && w_ext_edge);
  assign w_accept   = (r_state == S_IDLE) && w_trigger && !w_soft_rst;

  assign w_width_eff  = (r_width == 16'h0000) ? 16'h0001 : r_width;
  assign w_wid_done   = (r_wid_cnt == (w_width_eff - 16'h0001));
  assign w_last       = (r_repeat != 16'h0000) && (r_rep_cnt == r_repeat);
  // DELAY=0 chains repetitions back to back with no low cycle in between
  assign w_enter_high = !w_soft_rst &&
                        (((r_state == S_DLY) && (r_dly_cnt == r_delay)) ||
                         ((r_state == S_HIGH) && w_wid_done && !w_last && (r_delay == 16'h0000)));

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_ctrl   <= 8'h00;
      r_delay  <= 16'h0000;
      r_width  <= 16'h0001;
      r_repeat <= 16'h0001;
    end else if (w_soft_rst) begin
      r_ctrl   <= 8'h00;
      r_delay  <= 16'h0000;
      r_width  <= 16'h0001;
      r_repeat <= 16'h0001;
    end else if (w_wr) begin
      case (w_idx)
        4'd2:    r_ctrl          <= bus.BUS_DATA_IN;
        4'd3:    r_delay[7:0]    <= bus.BUS_DATA_IN;
        4'd4:    r_delay[15:8]   <= bus.BUS_DATA_IN;
        4'd5:    r_width[7:0]    <= bus.BUS_DATA_IN;
        4'd6:    r_width[15:8]   <= bus.BUS_DATA_IN;
        4'd7:    r_repeat[7:0]   <= bus.BUS_DATA_IN;
        4'd8:    r_repeat[15:8]  <= bus.BUS_DATA_IN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_sync <= 3'b000;
    end else begin
      r_sync <= {r_sync[1:0], EXT_START};
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_active  <= 1'b0;
      r_dly_cnt <= 16'h0000;
      r_wid_cnt <= 16'h0000;
      r_rep_cnt <= 16'h0000;
    end else if (w_soft_rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_active  <= 1'b0;
      r_dly_cnt <= 16'h0000;
      r_wid_cnt <= 16'h0000;
      r_rep_cnt <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_state   <= S_DLY;
            r_busy    <= 1'b1;
            r_dly_cnt <= 16'h0000;
            r_rep_cnt <= 16'h0001;
          end
        end
        S_DLY: begin
          if (r_dly_cnt == r_delay) begin
            r_state   <= S_HIGH;
            r_active  <= 1'b1;
            r_wid_cnt <= 16'h0000;
          end else begin
            r_dly_cnt <= r_dly_cnt + 16'h0001;
          end
        end
        S_HIGH: begin
          if (!w_wid_done) begin
            r_wid_cnt <= r_wid_cnt + 16'h0001;
          end else if (w_last) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_active <= 1'b0;
          end else begin
            if (r_rep_cnt != 16'hFFFF) begin
              r_rep_cnt <= r_rep_cnt + 16'h0001;
            end
            r_wid_cnt <= 16'h0000;
            if (r_delay != 16'h0000) begin
              r_state   <= S_DLY;
              r_active  <= 1'b0;
              r_dly_cnt <= 16'h0001;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

`ifdef CMD_PULSER_PULSE_CNT_EN
  logic [15:0] r_pulse_cnt;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_pulse_cnt <= 16'h0000;
    end else if (w_soft_rst || w_accept) begin
      r_pulse_cnt <= 16'h0000;
    end else if (w_enter_high && (r_pulse_cnt != 16'hFFFF)) begin
      r_pulse_cnt <= r_pulse_cnt + 16'h0001;
    end
  end

  assign w_pulse_cnt = r_pulse_cnt;
`else
  assign w_pulse_cnt = 16'h0000;
`endif

  always_comb begin
    w_rd_data = 8'h00;
    if (w_addr_ok) begin
      case (w_idx)
        4'd1:    w_rd_data = {7'b0000000, (r_state == S_IDLE)};
        4'd2:    w_rd_data = r_ctrl;
        4'd3:    w_rd_data = r_delay[7:0];
        4'd4:    w_rd_data = r_delay[15:8];
        4'd5:    w_rd_data = r_width[7:0];
        4'd6:    w_rd_data = r_width[15:8];
        4'd7:    w_rd_data = r_repeat[7:0];
        4'd8:    w_rd_data = r_repeat[15:8];
        4'd9:    w_rd_data = w_pulse_cnt[7:0];
        4'd10:   w_rd_data = w_pulse_cnt[15:8];
        default: w_rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_data_out <= 8'h00;
    end else begin
      r_data_out <= bus.BUS_RD ? w_rd_data : 8'h00;
    end
  end

  assign bus.BUS_DATA_OUT = r_data_out;
  assign PULSE_OUT        = r_active ^ r_ctrl[2];
  assign BUSY             = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_cmd_start_pulser.sv
// ---------------------------------------------------------------------------
// tb_cmd_start_pulser : directed self-checking bench for cmd_start_pulser.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cmd_start_pulser;

  logic clk;
  logic rst_n;
  logic ext_start;
  logic pulse_out;
  logic busy;
  int   vectors;
  int   miscompares;

  cmd_start_pulser_if bif ();

  cmd_start_pulser #(.BASEADDR_BITS(4)) dut (
    .BUS_CLK   (clk),
    .BUS_RST_N (rst_n),
    .bus       (bif),
    .EXT_START (ext_start),
    .PULSE_OUT (pulse_out),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bif.BUS_ADD     = a;
    bif.BUS_DATA_IN = d;
    bif.BUS_WR      = 1'b1;
    tick();
    bif.BUS_WR      = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bif.BUS_ADD = a;
    bif.BUS_RD  = 1'b1;
    tick();
    bif.BUS_RD  = 1'b0;
    d = bif.BUS_DATA_OUT;
  endtask

  initial begin
    logic [7:0]  rdat;
    logic [7:0]  exp_defaults [3:8];
    logic        seen;
    int          errs;
    int          highs;

    vectors         = 0;
    miscompares     = 0;
    rst_n           = 1'b0;
    ext_start       = 1'b1;
    bif.BUS_ADD     = 16'h0000;
    bif.BUS_DATA_IN = 8'h00;
    bif.BUS_RD      = 1'b0;
    bif.BUS_WR      = 1'b0;
    exp_defaults[3] = 8'h00; exp_defaults[4] = 8'h00; exp_defaults[5] = 8'h01;
    exp_defaults[6] = 8'h00; exp_defaults[7] = 8'h01; exp_defaults[8] = 8'h00;

    // Power-on reset state
    repeat (3) tick();
    check("por_pulse", 16'(pulse_out), 16'h0);
    check("por_busy", 16'(busy), 16'h0);
    check("por_dout", 16'(bif.BUS_DATA_OUT), 16'h00);
    rst_n = 1'b1;
    repeat (4) tick();
    rd(16'h0001, rdat);
    check("por_ready", 16'(rdat), 16'h01);

    // T1: long run, then async reset while the pulse is high
    wr(16'h0004, 8'h01);
    wr(16'h0005, 8'h05);
    wr(16'h0006, 8'h01);
    wr(16'h0007, 8'h00);
    wr(16'h0008, 8'h02);
    wr(16'h0001, 8'h00);
    repeat (270) tick();
    check("t1_pulse_pre", 16'(pulse_out), 16'h1);
    check("t1_busy_pre", 16'(busy), 16'h1);
    #3 rst_n = 1'b0;
    #1;
    check("t1_pulse_rst", 16'(pulse_out), 16'h0);
    check("t1_busy_rst", 16'(busy), 16'h0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int a = 3; a <= 8; a++) begin
      rd(16'(a), rdat);
      check($sformatf("t1_reg%0d", a), 16'(rdat), 16'(exp_defaults[a]));
    end
    rd(16'h0002, rdat);
    check("t1_reg2", 16'(rdat), 16'h00);

    // T2: DELAY=5 WIDTH=3 REPEAT=1; READY watched through a held read
    wr(16'h0003, 8'h05);
    wr(16'h0005, 8'h03);
    wr(16'h0007, 8'h01);
    wr(16'h0001, 8'h00);
    check("t2_busy_n", 16'(busy), 16'h1);
    bif.BUS_ADD = 16'h0001;
    bif.BUS_RD  = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check($sformatf("t2_pulse_n%0d", i), 16'(pulse_out), 16'((i >= 6) && (i <= 8)));
      check($sformatf("t2_busy_n%0d", i), 16'(busy), 16'(i <= 8));
      check($sformatf("t2_ready_n%0d", i), 16'(bif.BUS_DATA_OUT), 16'(i >= 10));
    end
    bif.BUS_RD = 1'b0;

    // Upper address bits set: write must be ignored
    wr(16'h0013, 8'h77);
    rd(16'h0003, rdat);
    check("t2_alias", 16'(rdat), 16'h05);

    // T3: DELAY=0 WIDTH=2 REPEAT=4 -> 8 contiguous high cycles
    wr(16'h0003, 8'h00);
    wr(16'h0005, 8'h02);
    wr(16'h0007, 8'h04);
    wr(16'h0001, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("t3_pulse_n%0d", i), 16'(pulse_out), 16'((i >= 1) && (i <= 8)));
    end
    rd(16'h0009, rdat);
`ifdef CMD_PULSER_PULSE_CNT_EN
    check("t3_cnt_lo", 16'(rdat), 16'h04);
`else
    check("t3_cnt_lo", 16'(rdat), 16'h00);
`endif
    rd(16'h000A, rdat);
    check("t3_cnt_hi", 16'(rdat), 16'h00);

    // T4: falling ext edge, DELAY=2 WIDTH=1; second edge while busy dropped
    wr(16'h0002, 8'h03);
    wr(16'h0003, 8'h02);
    wr(16'h0005, 8'h01);
    wr(16'h0007, 8'h01);
    ext_start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) ext_start = 1'b1;
      if (i == 2) ext_start = 1'b0;
      check($sformatf("t4_pulse_e%0d", i), 16'(pulse_out), 16'(i == 6));
      check($sformatf("t4_busy_e%0d", i), 16'(busy), 16'((i >= 3) && (i <= 6)));
    end
    wr(16'h0002, 8'h02);
    seen = 1'b0;
    ext_start = 1'b1;
    repeat (3) tick();
    ext_start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (pulse_out || busy) seen = 1'b1;
    end
    check("t4_disabled", 16'(seen), 16'h0);

    // T5: REPEAT=0 DELAY=1 WIDTH=1 -> free-running toggle until soft reset
    wr(16'h0003, 8'h01);
    wr(16'h0005, 8'h01);
    wr(16'h0007, 8'h00);
    wr(16'h0001, 8'h00);
    errs  = 0;
    highs = 0;
    for (int i = 1; i <= 1001; i++) begin
      tick();
      if (pulse_out !== ((i >= 2) && (i % 2 == 0))) errs++;
      if (pulse_out === 1'b1) highs++;
    end
    check("t5_toggle_errs", 16'(errs), 16'd0);
    check("t5_high_count", 16'(highs), 16'd500);
    wr(16'h0000, 8'h00);
    check("t5_srst_pulse", 16'(pulse_out), 16'h0);
    check("t5_srst_busy", 16'(busy), 16'h0);
    rd(16'h0001, rdat);
    check("t5_srst_ready", 16'(rdat), 16'h01);
    rd(16'h0003, rdat);
    check("t5_srst_delay", 16'(rdat), 16'h00);
    rd(16'h0007, rdat);
    check("t5_srst_repeat", 16'(rdat), 16'h01);

    // T6: inverted output; START and ext rising edge land on the same edge
    wr(16'h0002, 8'h05);
    check("t6_idle_inv", 16'(pulse_out), 16'h1);
    wr(16'h0005, 8'h03);
    ext_start = 1'b1;
    repeat (2) tick();
    wr(16'h0001, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("t6_pulse_n%0d", i), 16'(pulse_out), 16'(!((i >= 1) && (i <= 3))));
      check($sformatf("t6_busy_n%0d", i), 16'(busy), 16'(i <= 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
